// File: rtl/alu_exec.sv
// Execute stage: single-cycle logic/arith (result in cycle N+1, one op per cycle) and 8-step shift-add
// multiply / restoring divide (write-back in cycle N+W+1); o_ready is low while an iterative op is in flight.
module alu_exec #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ADDR_WIDTH-1:0] o_wb_reg,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic [3:0]            o_flags,
    output logic                  o_div0,
    output logic                  o_illegal
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;
    state_t state, state_nx;

    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [W-1:0]          a_q, b_q;
    logic [2*W-1:0]        acc, acc_nx;
    logic [CW-1:0]         cnt;
    logic                  accept, last_iter;

    logic [W:0]            wide_s;
    logic [W-1:0]          res_s;
    logic                  c_s, v_s;
    logic [3:0]            flags_s;

    logic [W-1:0]          mul_add;
    logic [W:0]            mul_sum;
    logic [W:0]            div_hi;
    logic [W+1:0]          div_trial;
    logic [W-1:0]          res_m;
    logic [3:0]            flags_m;

    assign o_ready   = (state == S_IDLE);
    assign accept    = i_valid && o_ready;
    assign last_iter = (cnt == CW'(1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && i_op[3] && !i_op[2]) begin
                    state_nx = i_op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_nx = S_WB;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wide_s = '0;
        res_s  = '0;
        c_s    = 1'b0;
        v_s    = 1'b0;
        case (i_op)
            4'd0: begin
                wide_s = {1'b0, i_a} + {1'b0, i_b};
                res_s  = wide_s[W-1:0];
                c_s    = wide_s[W];
                v_s    = (i_a[W-1] == i_b[W-1]) && (res_s[W-1] != i_a[W-1]);
            end
            4'd1: begin
                wide_s = {1'b0, i_a} - {1'b0, i_b};
                res_s  = wide_s[W-1:0];
                c_s    = wide_s[W];
                v_s    = (i_a[W-1] != i_b[W-1]) && (res_s[W-1] != i_a[W-1]);
            end
            4'd2: res_s = i_a & i_b;
            4'd3: res_s = i_a | i_b;
            4'd4: res_s = i_a ^ i_b;
            4'd5: begin
                res_s = {i_a[W-2:0], 1'b0};
                c_s   = i_a[W-1];
            end
            4'd6: begin
                res_s = {1'b0, i_a[W-1:1]};
                c_s   = i_a[0];
            end
            4'd7: res_s = i_b;
            default: res_s = '0;
        endcase
        flags_s = {res_s[W-1], v_s, c_s, ~|res_s};
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_add   = acc[0] ? a_q : '0;
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mul_add};
        div_hi    = acc[2*W-1:W-1];
        div_trial = {1'b0, div_hi} - {2'b00, b_q};
        if (state == S_MUL) begin
            acc_nx = {mul_sum, acc[W-1:1]};
        end else if (div_trial[W+1]) begin
            acc_nx = {div_hi[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_nx = {div_trial[W-1:0], acc[W-2:0], 1'b1};
        end
        res_m   = op_q[0] ? acc_nx[2*W-1:W] : acc_nx[W-1:0];
        flags_m = {res_m[W-1], 1'b0, (op_q == 4'd8) && (|acc_nx[2*W-1:W]), ~|res_m};
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            o_wb_reg  <= '0;
            o_wb_data <= '0;
            o_flags   <= '0;
            o_div0    <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            state     <= state_nx;
            o_wb_reg  <= '0;
            o_wb_data <= '0;
            o_div0    <= 1'b0;
            o_illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= i_op;
                        rd_q <= i_rd;
                        a_q  <= i_a;
                        b_q  <= i_b;
                        if (!i_op[3]) begin
                            o_wb_reg  <= i_rd;
                            o_wb_data <= (i_rd != '0) ? res_s : '0;
                            o_flags   <= flags_s;
                        end else if (i_op[2]) begin
                            o_illegal <= 1'b1;
                        end else begin
                            acc <= {{W{1'b0}}, (i_op[1] ? i_a : i_b)};
                            cnt <= CW'(W);
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= acc_nx;
                    cnt <= cnt - CW'(1);
                    if (last_iter) begin
                        o_wb_reg  <= rd_q;
                        o_wb_data <= (rd_q != '0) ? res_m : '0;
                        o_flags   <= flags_m;
                        o_div0    <= (state == S_DIV) && (b_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes expected write-backs from an arithmetic reference model,
// a negedge monitor pops and compares them on their due cycle and checks quiet outputs otherwise.
module tb_alu_exec;
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int FULL = 1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] a, b;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic [3:0]    flags;
    logic          div0, illegal;

    alu_exec #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_CLK(clk), .i_RST(rst), .i_valid(valid), .o_ready(ready),
        .i_op(op), .i_rd(rd), .i_a(a), .i_b(b),
        .o_wb_reg(wb_reg), .o_wb_data(wb_data), .o_flags(flags),
        .o_div0(div0), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [AW-1:0] wreg;
        logic [DW-1:0] data;
        logic [3:0]    fl;
        logic          d0;
        logic          ill;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         free_cyc = 0;
    logic [3:0] mflags = 4'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned/signed interpretations of the operands.
    function automatic void model(input logic [3:0] o, input int ai, input int bi,
                                  output int res, output logic [3:0] fl, output bit d0);
        int sa, sb, t;
        bit c, v;
        sa = (ai >= FULL / 2) ? ai - FULL : ai;
        sb = (bi >= FULL / 2) ? bi - FULL : bi;
        c  = 1'b0;
        v  = 1'b0;
        d0 = 1'b0;
        res = 0;
        case (o)
            4'd0: begin
                t = ai + bi; res = t % FULL; c = (t >= FULL);
                v = (sa + sb > FULL / 2 - 1) || (sa + sb < -FULL / 2);
            end
            4'd1: begin
                res = (ai - bi + FULL) % FULL; c = (ai < bi);
                v = (sa - sb > FULL / 2 - 1) || (sa - sb < -FULL / 2);
            end
            4'd2: res = ai & bi;
            4'd3: res = ai | bi;
            4'd4: res = ai ^ bi;
            4'd5: begin res = (ai * 2) % FULL; c = (ai >= FULL / 2); end
            4'd6: begin res = ai / 2; c = (ai % 2) != 0; end
            4'd7: res = bi;
            4'd8: begin t = ai * bi; res = t % FULL; c = (t / FULL) != 0; end
            4'd9: res = (ai * bi) / FULL;
            4'd10: begin res = (bi == 0) ? FULL - 1 : ai / bi; d0 = (bi == 0); end
            4'd11: begin res = (bi == 0) ? ai : ai % bi; d0 = (bi == 0); end
            default: res = 0;
        endcase
        fl = {res >= FULL / 2, v, c, res == 0};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] o, input int r, input int ai, input int bi, input bit track = 1'b1);
        int         res, n, g;
        logic [3:0] fl;
        bit         d0;
        exp_t       e;
        op = o; rd = AW'(r); a = DW'(ai); b = DW'(bi); valid = 1'b1;
        @(negedge clk);
        g = 0;
        while (cyc < free_cyc && g < 40) begin
            chk("ready_busy", 32'(ready), 32'd0);
            @(negedge clk);
            g++;
        end
        chk("ready_accept", 32'(ready), 32'd1);
        n = cyc;
        model(o, ai, bi, res, fl, d0);
        if (track) begin
            e.due = (o >= 4'd8 && o <= 4'd11) ? n + DW + 1 : n + 1;
            if (o >= 4'd12) begin
                e.wreg = '0; e.data = '0; e.fl = mflags; e.d0 = 1'b0; e.ill = 1'b1;
            end else begin
                e.wreg = AW'(r); e.data = (r != 0) ? DW'(res) : '0; e.fl = fl; e.d0 = d0; e.ill = 1'b0;
                mflags = fl;
            end
            exp_q.push_back(e);
        end
        free_cyc = (o >= 4'd8 && o <= 4'd11) ? n + DW + 2 : n + 1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op = 4'($urandom); rd = AW'($urandom); a = DW'($urandom); b = DW'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mflags = 4'b0;
        free_cyc = 0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                chk("wb_missed_due", 32'(cyc), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_reg", 32'(wb_reg), 32'(e.wreg));
                chk("wb_data", 32'(wb_data), 32'(e.data));
                chk("flags", 32'(flags), 32'(e.fl));
                chk("div0", 32'(div0), 32'(e.d0));
                chk("illegal", 32'(illegal), 32'(e.ill));
            end else begin
                chk("idle_wb_reg", 32'(wb_reg), 32'd0);
                chk("idle_wb_data", 32'(wb_data), 32'd0);
                chk("idle_div0", 32'(div0), 32'd0);
                chk("idle_illegal", 32'(illegal), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid = 1'b0; op = '0; rd = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_wb_reg", 32'(wb_reg), 32'd0);
        chk("reset_wb_data", 32'(wb_data), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_div0", 32'(div0), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0, 3, 200, 100);
        issue(4'd1, 1, 5, 5);
        issue(4'd4, 2, 'hF0, 'h0F);
        issue(4'd8, 4, 13, 20);
        issue(4'd9, 5, 13, 20);
        issue(4'd10, 6, 100, 7);
        issue(4'd11, 7, 100, 7);
        issue(4'd10, 8, 9, 0);
        issue(4'd11, 9, 9, 0);
        issue(4'd0, 0, 'h7F, 1);
        issue(4'd13, 10, 1, 2);
        issue(4'd0, 11, 'h80, 'h80);
        issue(4'd1, 12, 0, 1);
        issue(4'd5, 13, 'h81, 0);
        issue(4'd6, 14, 'h81, 0);
        issue(4'd8, 15, 255, 255);

        // Abort a multiply part-way through; no write-back may ever appear.
        issue(4'd8, 4, 13, 20, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        do_reset();
        repeat (12) begin @(posedge clk); #1; end
        issue(4'd0, 3, 1, 2);

        for (int i = 0; i < 200; i++) begin
            int ai, bi;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            ai = int'($urandom_range(0, FULL - 1));
            bi = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, FULL - 1));
            issue(4'($urandom_range(0, 15)), int'($urandom_range(0, (1 << AW) - 1)), ai, bi);
        end

        for (int g = 0; g < 40 && exp_q.size() != 0; g++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
